piso_bit_feeder: RTL and testbench

Parallel-in/serial-out feeder that sits directly upstream of the Moore sequence detector and drives its serial input x.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk.
- Qualifies each bit with x_valid and flags the final bit of each word.
- Supports gap-free back-to-back words, so the detector sees a contiguous stream.

---
 rtl/piso_bit_feeder_pkg.sv | 14 +
 rtl/piso_bit_feeder.sv | 91 +++++++++
 tb/tb_piso_bit_feeder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/piso_bit_feeder_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out bit feeder.
package piso_bit_feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a word of the given length (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_feeder.sv
// Serialises WIDTH-bit words one bit per clock for the downstream sequence
// detector, with gap-free reload so back-to-back words form a contiguous stream.
module piso_bit_feeder
  import piso_bit_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             x_last,
  output logic             busy
);

  localparam int unsigned   CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last_c;
  logic             accept_c;
  logic             head_c;
  logic [WIDTH-1:0] shifted_c;

  assign last_c    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign din_ready = rst && ((state_q == IDLE) || last_c);
  assign accept_c  = din_valid && din_ready;

  // Head bit and the register contents after one shift toward the head.
  assign head_c    = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign shifted_c = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

  // Serial outputs decode registered state only; din never reaches them.
  assign x_out   = (state_q == SHIFT) ? head_c : IDLE_BIT;
  assign x_valid = (state_q == SHIFT);
  assign x_last  = last_c;
  assign busy    = (state_q == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          sr_d    = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_c) begin
          // Reload on the last bit keeps x_valid high across the word boundary.
          if (accept_c) begin
            sr_d  = din;
            cnt_d = '0;
          end else begin
            sr_d    = shifted_c;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          sr_d  = shifted_c;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Directed bench: MSB-first feeder driven from a per-cycle vector table, plus an
// LSB-first instance (IDLE_BIT=1) and a mid-word reset checked by hand.
module tb_piso_bit_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] din_m, din_l;
  logic       vld_m, vld_l;
  logic       rdy_m, x_m, xv_m, xl_m, busy_m;
  logic       rdy_l, x_l, xv_l, xl_l, busy_l;

  int total;
  int passed;

  // One cycle of stimulus and the outputs expected in that same cycle.
  // exp packs {x_out, x_valid, x_last, din_ready, busy}.
  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(vld_m), .din_ready(rdy_m),
    .x_out(x_m), .x_valid(xv_m), .x_last(xl_m), .busy(busy_m)
  );

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(vld_l), .din_ready(rdy_l),
    .x_out(x_l), .x_valid(xv_l), .x_last(xl_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs_m();
    return {x_m, xv_m, xl_m, rdy_m, busy_m};
  endfunction

  function automatic logic [4:0] obs_l();
    return {x_l, xv_l, xl_l, rdy_l, busy_l};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got {x,v,last,rdy,busy}=%b required %b", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [4:0] e);
    vec_t r;
    r.vld = v;
    r.d   = d;
    r.exp = e;
    vecs.push_back(r);
  endtask

  // LSB-first word; seq lists the expected serial bits, first bit leftmost.
  task automatic run_lsb(input logic [7:0] word, input logic [7:0] seq, input string tag);
    din_l = word;
    vld_l = 1'b1;
    check({tag, " idle"}, obs_l(), 5'b10010);
    step();
    vld_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s bit%0d", tag, i + 1), obs_l(),
            {seq[7-i], 1'b1, (i == 7), (i == 7), 1'b1});
      step();
    end
    check({tag, " after"}, obs_l(), 5'b10010);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b0;
    din_m  = 8'hB4;
    vld_m  = 1'b1;
    din_l  = 8'h00;
    vld_l  = 1'b0;

    // Reset: outputs idle and din_ready low even with valid asserted.
    step();
    check("reset m", obs_m(), 5'b00000);
    check("reset l", obs_l(), 5'b10000);
    step();
    check("reset m hold", obs_m(), 5'b00000);
    vld_m = 1'b0;
    rst   = 1'b1;
    step();
    check("release m", obs_m(), 5'b00010);
    check("release l", obs_l(), 5'b10010);

    // Single word 8'hB4, MSB first.
    add(1, 8'hB4, 5'b00010);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b01001);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b01001);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b01001);
    add(0, 8'h00, 5'b01111);
    add(0, 8'h00, 5'b00010);
    // Back-to-back 8'hFF then 8'h00 with valid held high.
    add(1, 8'hFF, 5'b00010);
    for (int i = 0; i < 7; i++) add(1, 8'h00, 5'b11001);
    add(1, 8'h00, 5'b11111);
    for (int i = 0; i < 7; i++) add(1, 8'h00, 5'b01001);
    add(0, 8'h00, 5'b01111);
    add(0, 8'h00, 5'b00010);
    // 8'hAA presented from cycle 3 of 8'hB4; accepted only on the last bit.
    add(1, 8'hB4, 5'b00010);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b01001);
    add(1, 8'hAA, 5'b11001);
    add(1, 8'hAA, 5'b11001);
    add(1, 8'hAA, 5'b01001);
    add(1, 8'hAA, 5'b11001);
    add(1, 8'hAA, 5'b01001);
    add(1, 8'hAA, 5'b01111);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b01001);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b01001);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b01001);
    add(0, 8'h00, 5'b11001);
    add(0, 8'h00, 5'b01111);
    add(0, 8'h00, 5'b00010);

    foreach (vecs[i]) begin
      din_m = vecs[i].d;
      vld_m = vecs[i].vld;
      check($sformatf("vec%0d", i), obs_m(), vecs[i].exp);
      step();
    end
    vld_m = 1'b0;

    // LSB-first instance.
    run_lsb(8'h01, 8'b1000_0000, "lsb01");
    run_lsb(8'hB4, 8'b0010_1101, "lsbB4");

    // Reset after three bits of 8'hF0, then a fresh 8'h0F.
    din_m = 8'hF0;
    vld_m = 1'b1;
    check("rmw idle", obs_m(), 5'b00010);
    step();
    vld_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rmw bit%0d", i + 1), obs_m(), 5'b11001);
      if (i < 2) step();
    end
    #2;
    rst = 1'b0;
    #1;
    check("rmw async m", obs_m(), 5'b00000);
    check("rmw async l", obs_l(), 5'b10000);
    step();
    check("rmw held", obs_m(), 5'b00000);
    rst = 1'b1;
    step();
    check("rmw release", obs_m(), 5'b00010);
    din_m = 8'h0F;
    vld_m = 1'b1;
    step();
    vld_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rmw 0F bit%0d", i + 1), obs_m(),
            {(i >= 4), 1'b1, (i == 7), (i == 7), 1'b1});
      step();
    end
    check("rmw 0F after", obs_m(), 5'b00010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
